// File: rtl/ds_adc_multi_if.sv
// ds_adc_multi_if: pin bundle of the delta-sigma ADC core.
// master = ADC core side; slave = comparator/RC pins and host side.
// comp_in/trig into the core; pdm_out to RC nets; sout/sframe/sword/
// busy/dec_strobe to the host.
interface ds_adc_multi_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] comp_in;
  logic [CHANNELS-1:0] pdm_out;
  logic                trig;
  logic                sout;
  logic                sframe;
  logic                sword;
  logic                busy;
  logic                dec_strobe;

  modport master (
    input  comp_in, trig,
    output pdm_out, sout, sframe, sword, busy, dec_strobe
  );

  modport slave (
    output comp_in, trig,
    input  pdm_out, sout, sframe, sword, busy, dec_strobe
  );
endinterface

// File: rtl/ds_adc_multi.sv
// ds_adc_multi: multi-channel delta-sigma comparator ADC with CIC
// decimators and one shared triggered serialiser.
// Ports: clk, rst_n (async, active-low), bus (ds_adc_multi_if.master).
// Optional macro DS_ADC_DIFF_EN appends a filt[0]-filt[1] word
// to every frame when CHANNELS >= 2.
module ds_adc_multi #(
  parameter int CHANNELS   = 2,
  parameter int STAGES     = 3,
  parameter int DECIMATION = 8,
  parameter int WIDTH      = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  ds_adc_multi_if.master bus
);

  localparam int DW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
`ifdef DS_ADC_DIFF_EN
  localparam bit DIFF = (CHANNELS >= 2);
`else
  localparam bit DIFF = 1'b0;
`endif
  localparam int NWORDS = CHANNELS + (DIFF ? 1 : 0);
  localparam int WBW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BBW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  // Feedback flip-flops reset high so pdm_out starts low.
  logic [CHANNELS-1:0] r_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ff <= '1;
    else        r_ff <= bus.comp_in;
  end

  assign bus.pdm_out = ~r_ff;

  // Decimation counter
  logic [DW-1:0] r_dcnt;
  logic          r_strobe;
  logic          w_dec;

  assign w_dec = (r_dcnt == DW'(DECIMATION - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dcnt   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_dcnt   <= w_dec ? '0 : r_dcnt + 1'b1;
      r_strobe <= w_dec;
    end
  end

  assign bus.dec_strobe = r_strobe;

  // Per-channel CIC: integrators every clk, combs on w_dec.
  logic [WIDTH-1:0] w_filt [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] r_int [STAGES];
    logic [WIDTH-1:0] r_dly [STAGES];
    logic [WIDTH-1:0] w_cmb [STAGES+1];
    logic [WIDTH-1:0] r_filt;

    assign w_cmb[0] = r_int[STAGES-1];

    for (genvar s = 0; s < STAGES; s++) begin : g_cmb
      assign w_cmb[s+1] = w_cmb[s] - r_dly[s];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < STAGES; s++) begin
          r_int[s] <= '0;
          r_dly[s] <= '0;
        end
        r_filt <= '0;
      end else begin
        r_int[0] <= r_int[0] + WIDTH'(r_ff[c]);
        for (int s = 1; s < STAGES; s++)
          r_int[s] <= r_int[s] + r_int[s-1];
        if (w_dec) begin
          for (int s = 0; s < STAGES; s++)
            r_dly[s] <= w_cmb[s];
          r_filt <= w_cmb[STAGES];
        end
      end
    end

    assign w_filt[c] = r_filt;
  end

  // Snapshot source: channel words, then the optional diff word.
  logic [WIDTH-1:0] w_snap [NWORDS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_snap
    assign w_snap[c] = w_filt[c];
  end

  if (DIFF) begin : g_diff
    assign w_snap[NWORDS-1] = w_filt[0] - w_filt[1];
  end

  // Trigger synchroniser and rising-edge detect
  logic r_t1;
  logic r_t2;
  logic r_t3;
  logic w_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t1 <= 1'b0;
      r_t2 <= 1'b0;
      r_t3 <= 1'b0;
    end else begin
      r_t1 <= bus.trig;
      r_t2 <= r_t1;
      r_t3 <= r_t2;
    end
  end

  assign w_edge = r_t2 & ~r_t3;

  // Serialiser FSM
  state_t           r_state;
  state_t           w_state_nxt;
  logic [BBW-1:0]   r_bit;
  logic [BBW-1:0]   w_bit_nxt;
  logic [WBW-1:0]   r_word;
  logic [WBW-1:0]   w_word_nxt;
  logic             w_load;
  logic [WIDTH-1:0] r_shadow [NWORDS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bit   <= w_bit_nxt;
      r_word  <= w_word_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit;
    w_word_nxt  = r_word;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_edge) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = SHIFT;
        w_bit_nxt   = BBW'(WIDTH - 1);
        w_word_nxt  = '0;
      end
      SHIFT: begin
        if (r_bit == '0) begin
          if (r_word == WBW'(NWORDS - 1)) begin
            w_state_nxt = IDLE;
          end else begin
            w_word_nxt = r_word + 1'b1;
            w_bit_nxt  = BBW'(WIDTH - 1);
          end
        end else begin
          w_bit_nxt = r_bit - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A filt update on the LOAD edge is not seen: NBA keeps old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NWORDS; w++)
        r_shadow[w] <= '0;
    end else if (w_load) begin
      for (int w = 0; w < NWORDS; w++)
        r_shadow[w] <= w_snap[w];
    end
  end

  logic             w_frame;
  logic [WIDTH-1:0] w_cur;

  assign w_frame    = (r_state == SHIFT);
  assign w_cur      = r_shadow[r_word];
  assign bus.sframe = w_frame;
  assign bus.busy   = w_frame;
  assign bus.sout   = w_frame & w_cur[r_bit];
  assign bus.sword  = w_frame & (r_bit == BBW'(WIDTH - 1));

endmodule

// File: tb/tb_ds_adc_multi.sv
// tb_ds_adc_multi: randomized bench for ds_adc_multi.
// Expected words come from the CIC DC gain on periodic inputs.
module tb_ds_adc_multi;

  localparam int CH  = 2;
  localparam int ST  = 3;
  localparam int DEC = 8;
  localparam int W   = 13;
`ifdef DS_ADC_DIFF_EN
  localparam int NW = CH + ((CH >= 2) ? 1 : 0);
`else
  localparam int NW = CH;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ds_adc_multi_if #(.CHANNELS(CH)) bus ();

  ds_adc_multi #(
    .CHANNELS  (CH),
    .STAGES    (ST),
    .DECIMATION(DEC),
    .WIDTH     (W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int phase = 0;

  logic [DEC-1:0] pat   [CH];
  logic [W-1:0]   exp_w [NW];
  logic [W-1:0]   got_w [NW];

  // One cycle: step past the edge, then drive the periodic inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    phase++;
    for (int c = 0; c < CH; c++)
      bus.comp_in[c] = pat[c][phase % DEC];
  endtask

  // A DEC-periodic bit pattern through a STAGES-deep boxcar cascade
  // settles to popcount * DEC^(STAGES-1).
  function automatic void model();
    for (int c = 0; c < CH; c++)
      exp_w[c] = W'($countones(pat[c]) * (DEC ** (ST - 1)));
    if (NW > CH)
      exp_w[NW-1] = exp_w[0] - exp_w[1];
  endfunction

  // Pulse trig, collect one frame. lat = ticks until sframe (-1 none).
  task automatic capture(input int tcyc, output int lat,
                         output int len, output int fr_err);
    lat = -1;
    len = 0;
    fr_err = 0;
    for (int w = 0; w < NW; w++) got_w[w] = 'x;
    bus.trig = 1'b1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if (i == tcyc) bus.trig = 1'b0;
      if (bus.sframe === 1'b1) lat = i;
    end
    bus.trig = 1'b0;
    if (lat > 0) begin
      while (bus.sframe === 1'b1 && len < NW * W + 20) begin
        if (len < NW * W)
          got_w[len / W][W - 1 - (len % W)] = bus.sout;
        if (bus.sword !== ((len % W) == 0)) fr_err++;
        if (bus.busy !== bus.sframe) fr_err++;
        len++;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    int n;
    for (int c = 0; c < CH; c++) pat[c] = '0;
    bus.comp_in = '0;
    bus.trig = 1'b0;
    rst_n = 1'b0;
    #23;
    n_cmp++;
    if (bus.pdm_out !== '0) begin
      n_err++;
      $display("FAIL reset_pdm got %b want 0", bus.pdm_out);
    end
    n_cmp++;
    if (bus.sframe !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_sframe got %b want 0", bus.sframe);
    end
    n_cmp++;
    if (bus.dec_strobe !== 1'b0 || bus.sout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_strobe got %b want 0", bus.dec_strobe);
    end
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 3 * DEC && n == 0; i++) begin
      tick();
      if (i == 1) begin
        n_cmp++;
        if (bus.pdm_out !== '1) begin
          n_err++;
          $display("FAIL release_pdm got %b want all 1", bus.pdm_out);
        end
      end
      if (bus.dec_strobe === 1'b1) n = i;
    end
    n_cmp++;
    if (n != DEC) begin
      n_err++;
      $display("FAIL first_strobe got %0d want %0d", n, DEC);
    end
  endtask

  task automatic test_strobe();
    int n;
    int width;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      width = 0;
      for (int i = 1; i <= 3 * DEC && n == 0; i++) begin
        tick();
        if (bus.dec_strobe === 1'b1) n = i;
        else width++;
      end
      n_cmp++;
      if (n != DEC || width != DEC - 1) begin
        n_err++;
        $display("FAIL strobe_period got %0d want %0d", n, DEC);
      end
    end
  endtask

  task automatic test_frame(input string nm, input logic [DEC-1:0] p0,
                            input logic [DEC-1:0] p1, input int tcyc);
    int lat;
    int len;
    int fr_err;
    pat[0] = p0;
    pat[1] = p1;
    repeat (8 * DEC) tick();
    model();
    capture(tcyc, lat, len, fr_err);
    n_cmp++;
    if (lat != 4) begin
      n_err++;
      $display("FAIL %s_latency got %0d want 4", nm, lat);
    end
    n_cmp++;
    if (len != NW * W || fr_err != 0) begin
      n_err++;
      $display("FAIL %s_framing got len %0d err %0d want len %0d err 0",
               nm, len, fr_err, NW * W);
    end
    for (int w = 0; w < NW; w++) begin
      n_cmp++;
      if (got_w[w] !== exp_w[w]) begin
        n_err++;
        $display("FAIL %s_word%0d got %h want %h", nm, w, got_w[w], exp_w[w]);
      end
    end
  endtask

  task automatic test_random();
    logic [DEC-1:0] a;
    logic [DEC-1:0] b;
    for (int k = 0; k < 5; k++) begin
      a = DEC'($urandom);
      b = DEC'($urandom);
      test_frame("rand", a, b, int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_busy();
    int lat;
    int len;
    int extra;
    int fr_err;
    pat[0] = 8'hFF;
    pat[1] = 8'h55;
    repeat (8 * DEC) tick();
    model();
    lat = -1;
    len = 0;
    extra = 0;
    bus.trig = 1'b1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if (i == 2) bus.trig = 1'b0;
      if (bus.sframe === 1'b1) lat = i;
    end
    if (lat > 0) begin
      while (bus.sframe === 1'b1 && len < NW * W + 20) begin
        len++;
        if (len == 10) bus.trig = 1'b1;
        if (len == 12) bus.trig = 1'b0;
        tick();
      end
    end
    n_cmp++;
    if (len != NW * W) begin
      n_err++;
      $display("FAIL busy_len got %0d want %0d", len, NW * W);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.sframe !== 1'b0) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL busy_queued got %0d frame cycles want 0", extra);
    end
    capture(2, lat, len, fr_err);
    n_cmp++;
    if (lat != 4 || len != NW * W) begin
      n_err++;
      $display("FAIL busy_refire got lat %0d len %0d want 4 %0d",
               lat, len, NW * W);
    end
    for (int w = 0; w < NW; w++) begin
      n_cmp++;
      if (got_w[w] !== exp_w[w]) begin
        n_err++;
        $display("FAIL busy_word%0d got %h want %h", w, got_w[w], exp_w[w]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int lat;
    int len;
    int fr_err;
    int stray;
    model();
    lat = -1;
    stray = 0;
    bus.trig = 1'b1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if (i == 2) bus.trig = 1'b0;
      if (bus.sframe === 1'b1) lat = i;
    end
    repeat (20) tick();
    n_cmp++;
    if (bus.sframe !== 1'b1) begin
      n_err++;
      $display("FAIL mid_inframe got %b want 1", bus.sframe);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.sframe, bus.sout, bus.sword, bus.busy, bus.dec_strobe}
        !== 5'b0) begin
      n_err++;
      $display("FAIL mid_async got %b want 00000",
               {bus.sframe, bus.sout, bus.sword, bus.busy, bus.dec_strobe});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8 * DEC; i++) begin
      tick();
      if (bus.sframe !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      n_err++;
      $display("FAIL mid_resume got %0d frame cycles want 0", stray);
    end
    capture(2, lat, len, fr_err);
    n_cmp++;
    if (lat != 4 || len != NW * W || fr_err != 0) begin
      n_err++;
      $display("FAIL mid_fresh got lat %0d len %0d err %0d want 4 %0d 0",
               lat, len, fr_err, NW * W);
    end
    for (int w = 0; w < NW; w++) begin
      n_cmp++;
      if (got_w[w] !== exp_w[w]) begin
        n_err++;
        $display("FAIL mid_word%0d got %h want %h", w, got_w[w], exp_w[w]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_strobe();
    test_frame("dc_ones", 8'hFF, 8'hFF, 2);
    test_frame("half", 8'hFF, 8'h55, 2);
    test_frame("dc_zero", 8'h00, 8'h00, 1);
    test_random();
    test_busy();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ds_adc_multi.md
# ds_adc_multi

Parametrised multi-channel delta-sigma comparator ADC core: per-channel feedback flip-flop, inverted PDM drive, CIC decimator, and one shared triggered serialiser. It succeeds the fixed two-channel, three-serialiser top-level arrangement. All channels are snapshotted coherently on one trigger and shifted out as a single framed stream. It sits between the off-chip comparator/RC network pins and the host-facing output pins.

## Interface
- `CHANNELS`, 2: number of comparator channels (1–6).
- `STAGES`, 3: CIC integrator/comb stage count (1–4).
- `DECIMATION`, 8: CIC decimation ratio; power of two, 2–64.
- `WIDTH`, 13: CIC and output word width. Must be ≥ STAGES·log2(DECIMATION)+1.
- `clk`  in  1: system clock; also the delta-sigma sampling clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `comp_in`  in  CHANNELS: comparator outputs, one bit per channel.
- `pdm_out`  out  CHANNELS: inverted feedback flip-flop, driving each RC network.
- `trig`  in  1: asynchronous request to serialise one frame.
- `sout`  out  1: serial data, MSB first.
- `sframe`  out  1: high for every bit of a frame.
- `sword`  out  1: high on the first (MSB) bit of each word.
- `busy`  out  1: frame in progress; equals `sframe`.
- `dec_strobe`  out  1: one-cycle pulse when the filtered words update.

## Operation
- Feedback flip-flop per channel: `ff[i] <= comp_in[i]` every clk. `pdm_out[i] = ~ff[i]`.
- The CIC input per channel is `ff[i]` treated as unsigned 0/1.
- STAGES integrators run every clk. Integrators, combs, and the decimation counter use WIDTH-bit modular (wrap-around) arithmetic. Wrap is intentional and correct by CIC theory.
- A decimation counter counts 0..DECIMATION-1. On the count of DECIMATION-1, the combs update, `filt[i]` registers the new value, and `dec_strobe` pulses the next cycle.
- Constant input 1 settles to DECIMATION^STAGES (512 for defaults). Constant input 0 settles to 0.
- `trig` path: 2-flop synchroniser, then a rising-edge detect.
- FSM states:
  - IDLE: on edge, go to LOAD.
  - LOAD: one cycle. Snapshot all `filt[i]` (plus the optional diff word) into a shadow bank. Go to SHIFT.
  - SHIFT: NWORDS·WIDTH cycles, word 0 first. Then return to IDLE.
- NWORDS = CHANNELS, plus 1 when the diff word is enabled.
- During SHIFT, a bit counter counts WIDTH-1..0 and a word counter counts 0..NWORDS-1.
- `sout` is shadow[word][bit]. `sword` is high when bit = WIDTH-1.
- Filter updates during SHIFT do not alter the frame. The shadow bank is frozen.
- A trigger edge during LOAD/SHIFT is ignored. It is not queued.
- If a snapshot coincides with a `filt` update cycle, the snapshot takes the pre-update value.

## Timing
- Reset values:
  - `ff` = all 1, so `pdm_out` = 0 (capacitors charge).
  - `filt`, integrators, combs, counters = 0.
  - `sout`, `sframe`, `sword`, `busy`, `dec_strobe` = 0.
  - FSM in IDLE.
- `pdm_out` follows `comp_in` with one clk latency, inverted.
- `trig` high, first sampled at edge k: LOAD occupies the cycle after edge k+2, and `sframe` rises after edge k+3. The frame is exactly NWORDS·WIDTH cycles.
- After the frame ends there is at least one IDLE cycle before another frame.
- `dec_strobe` period is exactly DECIMATION cycles. The first pulse follows the DECIMATION-th edge after reset release.
- The CIC output reaches its steady value within (STAGES+1)·DECIMATION cycles of a constant input.
- Reset mid-frame: all outputs return to reset values immediately, asynchronously. No partial frame resumes.

## Configuration
- Macro `DS_ADC_DIFF_EN`.
- Defined and CHANNELS ≥ 2: the frame appends a final word `filt[0] - filt[1]` (WIDTH-bit modular). It is computed at LOAD from the same snapshot. NWORDS = CHANNELS+1.
- Undefined, or CHANNELS < 2: no diff word, no subtractor logic. NWORDS = CHANNELS.

## Test plan
- Reset check: assert `rst_n` low with `comp_in` = 0 -> `pdm_out` = 0, `sframe` = 0, `dec_strobe` = 0. After release, `pdm_out` = 2'b11 one cycle later.
- DC settling, defaults: `comp_in` = 2'b11 for 64 cycles -> ch0 and ch1 both equal 0x200. `dec_strobe` period is 8.
- Half scale: ch0 held 1 and ch1 toggling every clk, 64 cycles -> ch0 = 512, ch1 = 256.
- Frame, with `DS_ADC_DIFF_EN` defined, ch0 = 512, ch1 = 256, trig pulse of 2 cycles:
  - `sframe` rises 3 cycles after the first sample and stays high for 39 cycles.
  - Words read 0x0200, 0x0100, 0x0100.
  - `sword` pulses at bit offsets 0, 13, 26.
- Busy collision: a second trig edge 10 cycles into a frame -> no extra frame. A trig edge 2+ cycles after `sframe` falls -> a new frame.
- Reset mid-frame: `rst_n` low at frame bit 20 -> `sframe`/`sout` go to 0 asynchronously. After release, only a fresh trig starts a frame, and it begins at word 0.
